// File: rtl/callback_last_arbiter.sv
// Message-granular round-robin merge of NUM_CH show-ahead callback sources into one
// show-ahead output FIFO; every beat is tagged with its source channel and beat index.
module callback_last_arbiter #(
    parameter  int NUM_CH     = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    parameter  int IDX_W      = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            in_empty_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_in,
    input  logic [NUM_CH-1:0]            in_is_last_in,
    output logic [NUM_CH-1:0]            in_rden_out,
    input  logic                         out_rden_in,
    output logic [DATA_WIDTH-1:0]        out_data_out,
    output logic                         out_is_last_out,
    output logic [CH_W-1:0]              out_ch_out,
    output logic [IDX_W-1:0]             out_idx_out,
    output logic                         out_empty_out,
    output logic                         beat_overflow_out
);

    // state  | meaning
    // IDLE   | between messages; round-robin pick of next non-empty channel
    // LOCKED | mid-message; only channel g may be read until its is_last beat
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = DATA_WIDTH + 1 + CH_W + IDX_W;

    state_t                 state;
    logic [CH_W-1:0]        ptr;
    logic [CH_W-1:0]        g;
    logic [IDX_W-1:0]       beat_cnt;
    logic [ENT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;

    logic                   full;
    logic                   pop;
    logic                   any_ready;
    logic [CH_W-1:0]        sel;
    logic [CH_W-1:0]        rd_ch;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_last;
    logic [CH_W-1:0]        ptr_nxt;

    assign full = (count == (AW+1)'(DEPTH));
    assign pop  = out_rden_in && (count != '0);

    // Descending scan so the last hit wins: first non-empty channel at or after ptr.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            int c;
            c = (int'(ptr) + i) % NUM_CH;
            if (!in_empty_in[c]) begin
                any_ready = 1'b1;
                sel       = CH_W'(c);
            end
        end
    end

    always_comb begin
        rd_ch       = (state == LOCKED) ? g : sel;
        rd_en       = rst && !full && ((state == LOCKED) ? !in_empty_in[g] : any_ready);
        rd_data     = in_data_in[rd_ch*DATA_WIDTH +: DATA_WIDTH];
        rd_last     = in_is_last_in[rd_ch];
        ptr_nxt     = CH_W'((int'(rd_ch) + 1) % NUM_CH);
        in_rden_out = '0;
        if (rd_en) in_rden_out[rd_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            ptr               <= '0;
            g                 <= '0;
            beat_cnt          <= '0;
            beat_overflow_out <= 1'b0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (rd_en) begin
                mem[wr_ptr] <= {rd_data, rd_last, rd_ch, beat_cnt};
                wr_ptr      <= wr_ptr + 1'b1;
                if (rd_last) begin
                    beat_cnt <= '0;
                    state    <= IDLE;
                    ptr      <= ptr_nxt;
                end else begin
                    state <= LOCKED;
                    g     <= rd_ch;
                    if (beat_cnt == '1) begin
                        beat_cnt          <= '0;
                        beat_overflow_out <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({rd_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign {out_data_out, out_is_last_out, out_ch_out, out_idx_out} = mem[rd_ptr];
    assign out_empty_out = (count == '0);

endmodule

// File: tb/tb_callback_last_arbiter.sv
// Directed bench for callback_last_arbiter: queue-backed show-ahead sources on two
// channels, a stepping consumer, and field-by-field checks of every output beat.
module tb_callback_last_arbiter;

    localparam int NUM_CH = 2;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 4;
    localparam int CH_W   = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_CH-1:0]    in_empty_in = '1;
    logic [NUM_CH*DW-1:0] in_data_in = '0;
    logic [NUM_CH-1:0]    in_is_last_in = '0;
    logic [NUM_CH-1:0]    in_rden_out;
    logic                 out_rden_in = 1'b0;
    logic [DW-1:0]        out_data_out;
    logic                 out_is_last_out;
    logic [CH_W-1:0]      out_ch_out;
    logic [IDX_W-1:0]     out_idx_out;
    logic                 out_empty_out;
    logic                 beat_overflow_out;

    callback_last_arbiter #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_empty_in(in_empty_in), .in_data_in(in_data_in),
        .in_is_last_in(in_is_last_in), .in_rden_out(in_rden_out),
        .out_rden_in(out_rden_in), .out_data_out(out_data_out),
        .out_is_last_out(out_is_last_out), .out_ch_out(out_ch_out),
        .out_idx_out(out_idx_out), .out_empty_out(out_empty_out),
        .beat_overflow_out(beat_overflow_out)
    );

    always #5 clk = ~clk;

    // Source entries are {is_last, data}.
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];
    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;

    task automatic refresh();
        in_empty_in[0] = (q0.size() == 0);
        in_empty_in[1] = (q1.size() == 0);
        in_data_in[0*DW +: DW] = (q0.size() != 0) ? q0[0][DW-1:0] : '0;
        in_data_in[1*DW +: DW] = (q1.size() != 0) ? q1[0][DW-1:0] : '0;
        in_is_last_in[0] = (q0.size() != 0) ? q0[0][DW] : 1'b0;
        in_is_last_in[1] = (q1.size() != 0) ? q1[0][DW] : 1'b0;
    endtask

    // Pop a source one step after any edge at which its rden was high.
    always @(posedge clk) begin
        logic [NUM_CH-1:0] pend;
        pend = in_rden_out;
        #1;
        if (pend[0] && q0.size() != 0) void'(q0.pop_front());
        if (pend[1] && q1.size() != 0) void'(q1.pop_front());
        refresh();
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        out_rden_in = 1'b0;
        q0.delete();
        q1.delete();
        refresh();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int ch, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            if (ch == 0) q0.push_back({(k == n - 1), DW'(base + k)});
            else         q1.push_back({(k == n - 1), DW'(base + k)});
        end
        refresh();
    endtask

    // Called at a falling edge; consumes one beat and returns at the next falling edge.
    task automatic expect_beat(input string tag, input int data, input bit last,
                               input int ch, input int idx);
        int w;
        w = 0;
        while (out_empty_out && w < 50) begin
            @(negedge clk);
            w++;
            stalls++;
        end
        check({tag, " timeout"}, 64'(out_empty_out), 64'd0);
        check({tag, " data"}, 64'(out_data_out), 64'(data));
        check({tag, " last"}, 64'(out_is_last_out), 64'(last));
        check({tag, " ch"}, 64'(out_ch_out), 64'(ch));
        check({tag, " idx"}, 64'(out_idx_out), 64'(idx));
        out_rden_in = 1'b1;
        @(negedge clk);
        out_rden_in = 1'b0;
    endtask

    initial begin
        int w;
        int reads;
        refresh();
        @(negedge clk);
        // Reset values
        check("rst empty", 64'(out_empty_out), 64'd1);
        check("rst rden", 64'(in_rden_out), 64'd0);
        check("rst data", 64'(out_data_out), 64'd0);
        check("rst last", 64'(out_is_last_out), 64'd0);
        check("rst ch", 64'(out_ch_out), 64'd0);
        check("rst idx", 64'(out_idx_out), 64'd0);
        check("rst ovf", 64'(beat_overflow_out), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single channel, 16-beat message
        load(0, 16, 0);
        for (int k = 0; k < 16; k++) expect_beat("single", k, (k == 15), 0, k);

        // Two locked 16-beat messages, loaded while in reset
        do_reset();
        load(0, 16, 0);
        load(1, 16, 100);
        rst = 1'b1;
        for (int i = 0; i < 32; i++)
            expect_beat("lock", (i < 16) ? i : 100 + i - 16, (i % 16 == 15), i / 16, i % 16);

        // Alternating 1-beat messages at full rate
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q0.push_back({1'b1, DW'(k)});
            q1.push_back({1'b1, DW'(50 + k)});
        end
        refresh();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_beat("alt", (i % 2 == 0) ? i / 2 : 50 + i / 2, 1'b1, i % 2, 0);
            if (i == 0) stalls = 0;
        end
        check("alt stalls", 64'(stalls), 64'd0);

        // Backpressure: FIFO fills at DEPTH, then drains in order
        do_reset();
        rst = 1'b1;
        load(0, 10, 0);
        repeat (10) @(negedge clk);
        check("full remaining", 64'(q0.size()), 64'd6);
        check("full rden", 64'(in_rden_out), 64'd0);
        check("full empty", 64'(out_empty_out), 64'd0);
        for (int k = 0; k < 10; k++) expect_beat("drain", k, (k == 9), 0, k);

        // Beat-index overflow on a 20-beat message
        do_reset();
        rst = 1'b1;
        load(0, 20, 0);
        for (int k = 0; k < 20; k++) begin
            expect_beat("ovf beat", k, (k == 19), 0, (k < 16) ? k : k - 16);
            reads = 20 - q0.size();
            if (reads <= 15)      check("ovf early", 64'(beat_overflow_out), 64'd0);
            else if (reads >= 17) check("ovf set", 64'(beat_overflow_out), 64'd1);
        end
        repeat (3) @(negedge clk);
        check("ovf sticky", 64'(beat_overflow_out), 64'd1);
        do_reset();
        check("ovf cleared", 64'(beat_overflow_out), 64'd0);

        // Asynchronous reset mid-message on ch1
        rst = 1'b1;
        load(1, 10, 200);
        out_rden_in = 1'b1;
        w = 0;
        while (q1.size() > 5 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("mid timeout", 64'(w < 100), 64'd1);
        check("mid read count", 64'(q1.size()), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        check("mid empty", 64'(out_empty_out), 64'd1);
        check("mid rden", 64'(in_rden_out), 64'd0);
        out_rden_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) expect_beat("mid resume", 205 + k, (k == 4), 1, k);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
